// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 1 << AW;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wb_entry;

    function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] wa);
        reg_onehot = NREG'(1) << wa;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// In-order buffer of MDU results with per-entry valid bits and kill-by-address.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [AW-1:0]   push_wa,
    input  logic [DW-1:0]   push_wd,
    input  logic            pop,
    input  logic            kill_en,
    input  logic [AW-1:0]   kill_wa,
    output wb_entry         head,
    output logic [CW-1:0]   count,
    output logic            any_valid,
    output logic [NREG-1:0] pending_mask
);

    wb_entry         mem_q [DEPTH];
    wb_entry         mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Kill first, then pop, then push: a same-cycle push to the killed address survives.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill_en && mem_q[PW'(i)].valid && (mem_q[PW'(i)].wa == kill_wa)) begin
                mem_d[PW'(i)].valid = 1'b0;
            end
        end
        if (pop) begin
            mem_d[rd_ptr_q].valid = 1'b0;
        end
        if (push) begin
            mem_d[wr_ptr_q] = '{valid: 1'b1, wa: push_wa, wd: push_wd};
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[PW'(i)] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[PW'(i)] <= mem_d[PW'(i)];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Hazard view: every register still owed a buffered result.
    always_comb begin
        pending_mask = '0;
        any_valid    = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem_q[PW'(i)].valid) begin
                pending_mask = pending_mask | reg_onehot(mem_q[PW'(i)].wa);
                any_valid    = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges pipeline writeback and buffered MDU results onto the single register-file write port.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_we,
    input  logic [AW-1:0]   pipe_wa,
    input  logic [DW-1:0]   pipe_wd,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [AW-1:0]   mdu_wa,
    input  logic [DW-1:0]   mdu_wd,
    output logic            we3,
    output logic [AW-1:0]   wa3,
    output logic [DW-1:0]   wd3,
    output logic [NREG-1:0] pending_mask,
    output logic            pipe_stall
);

    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT - 1);

    wb_entry          head;
    logic [CW-1:0]    count;
    logic             any_valid;
    logic             pw, acc, mdu_live, head_valid, skip_pop;
    logic             pop, push, bypass;
    logic             we3_q, we3_d;
    logic [AW-1:0]    wa3_q, wa3_d;
    logic [DW-1:0]    wd3_q, wd3_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             stall_q, stall_d;

    assign pw         = pipe_we && (pipe_wa != REG_ZERO);
    assign mdu_ready  = !reset && (count < CW'(DEPTH));
    assign acc        = mdu_valid && mdu_ready;
    assign mdu_live   = acc && (mdu_wa != REG_ZERO);
    assign head_valid = (count != '0) && head.valid;
    assign skip_pop   = (count != '0) && !head.valid;

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_wa      (mdu_wa),
        .push_wd      (mdu_wd),
        .pop          (pop),
        .kill_en      (pw),
        .kill_wa      (pipe_wa),
        .head         (head),
        .count        (count),
        .any_valid    (any_valid),
        .pending_mask (pending_mask)
    );

    // Slot priority: pipeline, then buffered head, then bypass; bypass only when no older result waits.
    always_comb begin
        we3_d  = 1'b0;
        wa3_d  = '0;
        wd3_d  = '0;
        pop    = skip_pop;
        bypass = 1'b0;
        if (pw) begin
            we3_d = 1'b1;
            wa3_d = pipe_wa;
            wd3_d = pipe_wd;
        end else if (head_valid) begin
            pop   = 1'b1;
            we3_d = 1'b1;
            wa3_d = head.wa;
            wd3_d = head.wd;
        end else if (mdu_live && !any_valid) begin
            bypass = 1'b1;
            we3_d  = 1'b1;
            wa3_d  = mdu_wa;
            wd3_d  = mdu_wd;
        end
        push = mdu_live && !bypass;
    end

    // Head age saturates; stall is held until the head is finally written.
    always_comb begin
        age_d   = '0;
        stall_d = 1'b0;
        if (head_valid && !pop) begin
            age_d   = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);
            stall_d = (age_q >= AGE_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
            age_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
            age_q   <= age_d;
            stall_q <= stall_d;
        end
    end

    assign we3        = we3_q;
    assign wa3        = wa3_q;
    assign wd3        = wd3_q;
    assign pipe_stall = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected writes queued at drive time, matched on we3.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            pipe_we;
    logic [AW-1:0]   pipe_wa;
    logic [DW-1:0]   pipe_wd;
    logic            mdu_valid;
    logic            mdu_ready;
    logic [AW-1:0]   mdu_wa;
    logic [DW-1:0]   mdu_wd;
    logic            we3;
    logic [AW-1:0]   wa3;
    logic [DW-1:0]   wd3;
    logic [NREG-1:0] pending_mask;
    logic            pipe_stall;

    exp_t exp_q[$];
    int   n_asserts = 0;
    int   n_fails   = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_we      (pipe_we),
        .pipe_wa      (pipe_wa),
        .pipe_wd      (pipe_wd),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_wa       (mdu_wa),
        .mdu_wd       (mdu_wd),
        .we3          (we3),
        .wa3          (wa3),
        .wd3          (wd3),
        .pending_mask (pending_mask),
        .pipe_stall   (pipe_stall)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic pwe, input logic [AW-1:0] pwa, input logic [DW-1:0] pwd,
                         input logic mv, input logic [AW-1:0] mwa, input logic [DW-1:0] mwd);
        @(posedge clk);
        #1;
        pipe_we   = pwe;
        pipe_wa   = pwa;
        pipe_wd   = pwd;
        mdu_valid = mv;
        mdu_wa    = mwa;
        mdu_wd    = mwd;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic expect_wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        exp_q.push_back('{wa: wa, wd: wd});
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_asserts++;
        if ({we3, wa3, wd3, pipe_stall} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got we3=%0b wa3=%0d wd3=%h stall=%0b, want all zero", we3, wa3, wd3, pipe_stall);
        end
        n_asserts++;
        if (mdu_ready !== 1'b0 || pending_mask !== '0) begin
            n_fails++;
            $display("FAIL reset_ready: got ready=%0b mask=%h, want 0/0", mdu_ready, pending_mask);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (mdu_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_release_ready: got %0b, want 1", mdu_ready);
        end
    endtask

    task automatic test_pipe_write();
        drive(1'b1, 5'd5, 32'hA5A5, 1'b0, '0, '0);
        expect_wr(5'd5, 32'hA5A5);
        idle();
        @(negedge clk);
        n_asserts++;
        if (we3 !== 1'b1 || wa3 !== 5'd5 || wd3 !== 32'hA5A5) begin
            n_fails++;
            $display("FAIL pipe_write: got %0b/%0d/%h, want 1/5/0000a5a5", we3, wa3, wd3);
        end
        idle();
        @(negedge clk);
        n_asserts++;
        if (we3 !== 1'b0 || wa3 !== '0 || wd3 !== '0) begin
            n_fails++;
            $display("FAIL pipe_idle: got %0b/%0d/%h, want 0/0/0", we3, wa3, wd3);
        end
        repeat (3) idle();
        @(negedge clk);
        n_asserts++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL pipe_write_drain: %0d writes missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_buffer_order();
        drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd7, 32'h11);
        expect_wr(5'd3, 32'h300);
        @(negedge clk);
        n_asserts++;
        if (mdu_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL order_ready0: got %0b, want 1", mdu_ready);
        end
        drive(1'b1, 5'd3, 32'h301, 1'b1, 5'd8, 32'h22);
        expect_wr(5'd3, 32'h301);
        drive(1'b1, 5'd3, 32'h302, 1'b0, '0, '0);
        expect_wr(5'd3, 32'h302);
        @(negedge clk);
        n_asserts++;
        if (mdu_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL order_full_ready: got %0b, want 0", mdu_ready);
        end
        n_asserts++;
        if (pending_mask !== 32'h0000_0180) begin
            n_fails++;
            $display("FAIL order_pending: got %h, want 00000180", pending_mask);
        end
        expect_wr(5'd7, 32'h11);
        expect_wr(5'd8, 32'h22);
        repeat (5) idle();
        @(negedge clk);
        n_asserts++;
        if (exp_q.size() != 0 || pending_mask !== '0) begin
            n_fails++;
            $display("FAIL order_drain: %0d writes missing, mask=%h, want 0/0", exp_q.size(), pending_mask);
        end
    endtask

    task automatic test_waw_kill();
        drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd9, 32'h1234);
        expect_wr(5'd2, 32'h2222);
        drive(1'b1, 5'd9, 32'hBEEF, 1'b0, '0, '0);
        expect_wr(5'd9, 32'hBEEF);
        @(negedge clk);
        n_asserts++;
        if (pending_mask !== 32'h0000_0200) begin
            n_fails++;
            $display("FAIL kill_pending_set: got %h, want 00000200", pending_mask);
        end
        idle();
        @(negedge clk);
        n_asserts++;
        if (pending_mask !== '0 || wa3 !== 5'd9 || wd3 !== 32'hBEEF) begin
            n_fails++;
            $display("FAIL kill_write: got mask=%h wa3=%0d wd3=%h, want 0/9/0000beef", pending_mask, wa3, wd3);
        end
        idle();
        @(negedge clk);
        n_asserts++;
        if (we3 !== 1'b0 || mdu_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL kill_skip: got we3=%0b ready=%0b, want 0/1", we3, mdu_ready);
        end
        repeat (3) idle();
        @(negedge clk);
        n_asserts++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL kill_drain: %0d writes missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_starvation();
        logic exp_stall;
        drive(1'b1, 5'd4, 32'h400, 1'b1, 5'd10, 32'h55);
        expect_wr(5'd4, 32'h400);
        for (int c = 1; c <= 9; c++) begin
            drive(1'b1, 5'd4, 32'h400 + DW'(c), 1'b0, '0, '0);
            expect_wr(5'd4, 32'h400 + DW'(c));
            @(negedge clk);
            exp_stall = (c == 9);
            n_asserts++;
            if (pipe_stall !== exp_stall) begin
                n_fails++;
                $display("FAIL starve_cycle%0d: got stall=%0b, want %0b", c, pipe_stall, exp_stall);
            end
        end
        idle();
        expect_wr(5'd10, 32'h55);
        @(negedge clk);
        n_asserts++;
        if (pipe_stall !== 1'b1) begin
            n_fails++;
            $display("FAIL starve_hold: got %0b, want 1", pipe_stall);
        end
        idle();
        @(negedge clk);
        n_asserts++;
        if (pipe_stall !== 1'b0 || we3 !== 1'b1 || wa3 !== 5'd10) begin
            n_fails++;
            $display("FAIL starve_release: got stall=%0b we3=%0b wa3=%0d, want 0/1/10", pipe_stall, we3, wa3);
        end
        repeat (3) idle();
        @(negedge clk);
        n_asserts++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL starve_drain: %0d writes missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd6, 32'h77);
        expect_wr(5'd6, 32'h77);
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h99);
        @(negedge clk);
        n_asserts++;
        if (we3 !== 1'b1 || wa3 !== 5'd6 || wd3 !== 32'h77 || pending_mask !== '0) begin
            n_fails++;
            $display("FAIL bypass: got %0b/%0d/%h mask=%h, want 1/6/00000077 mask 0", we3, wa3, wd3, pending_mask);
        end
        n_asserts++;
        if (mdu_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL zero_accept_ready: got %0b, want 1", mdu_ready);
        end
        idle();
        @(negedge clk);
        n_asserts++;
        if (we3 !== 1'b0 || pending_mask !== '0) begin
            n_fails++;
            $display("FAIL zero_discard: got we3=%0b mask=%h, want 0/0", we3, pending_mask);
        end
        repeat (3) idle();
        @(negedge clk);
        n_asserts++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL bypass_drain: %0d writes missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 5'd3, 32'h30, 1'b1, 5'd11, 32'hAA);
        expect_wr(5'd3, 32'h30);
        drive(1'b1, 5'd3, 32'h31, 1'b1, 5'd12, 32'hBB);
        expect_wr(5'd3, 32'h31);
        drive(1'b1, 5'd3, 32'h32, 1'b0, '0, '0);
        expect_wr(5'd3, 32'h32);
        @(negedge clk);
        n_asserts++;
        if (pending_mask !== 32'h0000_1800) begin
            n_fails++;
            $display("FAIL mid_pending: got %h, want 00001800", pending_mask);
        end
        idle();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_asserts++;
        if (we3 !== 1'b0 || wa3 !== '0 || wd3 !== '0 || mdu_ready !== 1'b0 || pending_mask !== '0) begin
            n_fails++;
            $display("FAIL mid_reset_async: got %0b/%0d/%h ready=%0b mask=%h, want all 0", we3, wa3, wd3, mdu_ready, pending_mask);
        end
        @(negedge clk);
        n_asserts++;
        if (we3 !== 1'b0 || mdu_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_reset_hold: got we3=%0b ready=%0b, want 0/0", we3, mdu_ready);
        end
        #1 reset = 1'b0;
        #1;
        n_asserts++;
        if (mdu_ready !== 1'b1 || pending_mask !== '0) begin
            n_fails++;
            $display("FAIL mid_release: got ready=%0b mask=%h, want 1/0", mdu_ready, pending_mask);
        end
        repeat (4) idle();
        @(negedge clk);
        n_asserts++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL mid_drain: %0d writes missing, want 0", exp_q.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        pipe_we   = 1'b0;
        pipe_wa   = '0;
        pipe_wd   = '0;
        mdu_valid = 1'b0;
        mdu_wa    = '0;
        mdu_wd    = '0;

        // Write-port scoreboard: every write must match the oldest expectation; idle means 0/0/0.
        fork
            forever begin
                @(negedge clk);
                n_asserts++;
                if (we3 === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_fails++;
                        $display("FAIL wr_unexpected: got wa3=%0d wd3=%h, want no write", wa3, wd3);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (wa3 !== e.wa || wd3 !== e.wd) begin
                            n_fails++;
                            $display("FAIL wr_data: got wa3=%0d wd3=%h, want wa3=%0d wd3=%h", wa3, wd3, e.wa, e.wd);
                        end
                    end
                end else if (we3 !== 1'b0 || wa3 !== '0 || wd3 !== '0) begin
                    n_fails++;
                    $display("FAIL wr_idle: got we3=%0b wa3=%0d wd3=%h, want 0/0/0", we3, wa3, wd3);
                end
            end
        join_none

        test_reset();
        test_pipe_write();
        test_buffer_order();
        test_waw_kill();
        test_starvation();
        test_bypass();
        test_reset_midstream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
